// File: rtl/bfm_pkg.sv
// Shared widths and types for the bfm adder datapath.
package bfm_pkg;

  localparam int BFM_WIDTH       = 8;
  localparam int BFM_MAX_LATENCY = 4;

  typedef logic [BFM_WIDTH-1:0] bfm_data_t;

endpackage

// File: rtl/bfm_pipe_stage.sv
// One WIDTH-wide register of the adder pipeline with a synchronous clear.
module bfm_pipe_stage
  import bfm_pkg::*;
#(
  parameter int WIDTH = BFM_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (reset_i) q <= '0;
    else         q <= d;
  end

endmodule

// File: rtl/bfm_adder.sv
// Registered modular adder: res_o = (A_s + B_s) mod 2**WIDTH, LATENCY stages late.
module bfm_adder
  import bfm_pkg::*;
#(
  parameter int WIDTH   = BFM_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o
);

  if (LATENCY < 1 || LATENCY > BFM_MAX_LATENCY) begin : g_bad_latency
    $error("bfm_adder: LATENCY=%0d outside 1..%0d", LATENCY, BFM_MAX_LATENCY);
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] pipe [LATENCY];

  // Carry-out falls off the top: the assignment truncates to WIDTH.
  assign sum = A_s + B_s;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      bfm_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d      (sum),
        .q      (pipe[g])
      );
    end else begin : g_next
      bfm_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d      (pipe[g-1]),
        .q      (pipe[g])
      );
    end
  end

  assign res_o = pipe[LATENCY-1];

endmodule

// File: tb/tb_bfm_adder.sv
// Directed bench for bfm_adder at LATENCY=1 and LATENCY=3 sharing one stimulus.
module tb_bfm_adder;
  import bfm_pkg::*;

  logic      clk_i = 1'b0;
  logic      reset_i;
  bfm_data_t a_s, b_s;
  bfm_data_t res1, res3;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bfm_adder #(.WIDTH(BFM_WIDTH), .LATENCY(1)) dut1 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .A_s    (a_s),
    .B_s    (b_s),
    .res_o  (res1)
  );

  bfm_adder #(.WIDTH(BFM_WIDTH), .LATENCY(3)) dut3 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .A_s    (a_s),
    .B_s    (b_s),
    .res_o  (res3)
  );

  task automatic check(input string tag, input bfm_data_t got, input bfm_data_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bfm_data_t exp_s;

    reset_i = 1'b1;
    a_s     = 8'h12;
    b_s     = 8'h34;

    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_l1", res1, 8'h00);
      check("reset_l3", res3, 8'h00);
    end

    // First post-reset operands: L1 shows them after one edge, L3 after three.
    reset_i = 1'b0;
    a_s     = 8'd3;
    b_s     = 8'd4;
    step();
    check("add_l1", res1, 8'd7);
    check("add_l3_e0", res3, 8'd0);
    step();
    check("add_l3_e1", res3, 8'd0);
    step();
    check("add_l3_e2", res3, 8'd7);

    a_s = 8'hFF;
    b_s = 8'h01;
    step();
    check("wrap_ff_01", res1, 8'h00);
    a_s = 8'h80;
    b_s = 8'h80;
    step();
    check("wrap_80_80", res1, 8'h00);
    check("wrap_l3_hold", res3, 8'd7);

    for (int i = 0; i < 100; i++) begin
      a_s = 8'(i);
      b_s = 8'(2 * i);
      step();
      exp_s = 8'(3 * i);
      check("stream_l1", res1, exp_s);
      if (i >= 2) begin
        exp_s = 8'(3 * (i - 2));
        check("stream_l3", res3, exp_s);
      end
    end

    // 10+20 sampled at edge N; reset at N+1 must flush it before it reaches res_o.
    a_s = 8'd10;
    b_s = 8'd20;
    step();
    check("flush_l1_n", res1, 8'd30);
    exp_s = 8'(3 * 98);
    check("flush_l3_n", res3, exp_s);
    a_s     = 8'd0;
    b_s     = 8'd0;
    reset_i = 1'b1;
    step();
    check("flush_l1_rst", res1, 8'd0);
    check("flush_l3_rst", res3, 8'd0);
    reset_i = 1'b0;
    a_s     = 8'd5;
    b_s     = 8'd6;
    step();
    check("flush_l3_n2", res3, 8'd0);
    check("resume_l1", res1, 8'd11);
    step();
    check("flush_l3_n3", res3, 8'd0);
    step();
    check("resume_l3", res3, 8'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
